// File: rtl/serial_transmitter_if.sv
// Port bundle for the parallel-to-serial transmitter.
// Handshake: a word moves on the rising edge where load_valid && load_ready; the source holds
// parallel_data_input and load_valid stable until that edge, and load_ready never waits on load_valid.
interface serial_transmitter_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] parallel_data_input;
   logic             load_valid;
   logic             load_ready;
   logic             shift_enable;
   logic             serial_data_output;
   logic             serial_valid;
   logic             last_bit;
   logic             busy;
   // Debug view of the FSM state and bit counter.
   logic             dbg_state;
   logic [CW-1:0]    dbg_count;

   modport master (
      output parallel_data_input, load_valid, shift_enable,
      input  load_ready, serial_data_output, serial_valid, last_bit, busy,
             dbg_state, dbg_count
   );

   modport slave (
      input  parallel_data_input, load_valid, shift_enable,
      output load_ready, serial_data_output, serial_valid, last_bit, busy,
             dbg_state, dbg_count
   );
endinterface

// File: rtl/serial_transmitter.sv
// Parallel-to-serial transmitter: accepts a word on a valid/ready handshake and emits it one bit
// per shift_enable strobe, with frame-valid and last-bit markers; back-to-back frames have no gap.
module serial_transmitter #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 sync_reset,
   serial_transmitter_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic is_last;
   logic ready;
   logic accept;

   assign is_last = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
   // A new word may enter while the final bit is being strobed out, giving gapless frames.
   assign ready   = !sync_reset && ((state_q == IDLE) || (is_last && bus.shift_enable));
   assign accept  = bus.load_valid && ready;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = SHIFT;
         shreg_d = bus.parallel_data_input;
         cnt_d   = '0;
      end else if ((state_q == SHIFT) && bus.shift_enable) begin
         if (is_last) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end else begin
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // The output end of the register is zero whenever the FSM is idle.
   assign bus.serial_data_output = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   assign bus.serial_valid       = (state_q == SHIFT);
   assign bus.busy               = (state_q == SHIFT);
   assign bus.last_bit           = is_last;
   assign bus.load_ready         = ready;
   assign bus.dbg_state          = state_q;
   assign bus.dbg_count          = cnt_q;
endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: an MSB-first and an LSB-first instance share the same stimulus.
// A table of frames plus hand-written sequences; a scoreboard checks every strobed bit.
module tb_serial_transmitter;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic       valid;
   logic       en;

   int n_cmp = 0;
   int n_err = 0;
   bit mon_on = 1'b0;

   logic [1:0] exp_m_q[$];
   logic [1:0] exp_l_q[$];

   always #5 clk = ~clk;

   serial_transmitter_if #(.WIDTH(8)) bus_m ();
   serial_transmitter_if #(.WIDTH(8)) bus_l ();

   assign bus_m.parallel_data_input = data;
   assign bus_m.load_valid          = valid;
   assign bus_m.shift_enable        = en;
   assign bus_l.parallel_data_input = data;
   assign bus_l.load_valid          = valid;
   assign bus_l.shift_enable        = en;

   serial_transmitter #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .sync_reset(rst), .bus(bus_m)
   );
   serial_transmitter #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .sync_reset(rst), .bus(bus_l)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expected {last, bit} pairs are queued on accept and popped on each strobed bit.
   always @(negedge clk) begin
      logic [1:0] e;
      if (mon_on) begin
         chk("valid_eq_busy", {bus_m.serial_valid, bus_l.serial_valid}, {bus_m.busy, bus_l.busy});
         if (!bus_m.busy) chk("idle_out_m", {bus_m.serial_data_output, bus_m.last_bit}, 2'b00);
         if (!bus_l.busy) chk("idle_out_l", {bus_l.serial_data_output, bus_l.last_bit}, 2'b00);
         if (bus_m.serial_valid && en) begin
            if (exp_m_q.size() == 0) chk("sb_empty_m", 1, 0);
            else begin
               e = exp_m_q.pop_front();
               chk("sb_bit_m", {bus_m.last_bit, bus_m.serial_data_output}, e);
            end
         end
         if (bus_l.serial_valid && en) begin
            if (exp_l_q.size() == 0) chk("sb_empty_l", 1, 0);
            else begin
               e = exp_l_q.pop_front();
               chk("sb_bit_l", {bus_l.last_bit, bus_l.serial_data_output}, e);
            end
         end
         if (rst) begin
            exp_m_q.delete();
            exp_l_q.delete();
         end else if (valid && bus_m.load_ready) begin
            for (int i = 0; i < 8; i++) begin
               exp_m_q.push_back({(i == 7), data[7-i]});
               exp_l_q.push_back({(i == 7), data[i]});
            end
         end
      end
   end

   typedef struct {
      logic [7:0] word;
      int         stall_bit;
      int         stall_len;
      logic [7:0] exp_m;
      logic [7:0] exp_l;
      int         exp_cycles;
   } vec_t;

   vec_t vecs[4];

   task automatic run_frame(input vec_t v, input string tag);
      int         consumed, stalled, cycles, guard;
      logic [7:0] rec_m, rec_l;
      consumed = 0; stalled = 0; cycles = 0; rec_m = '0; rec_l = '0;
      @(posedge clk); #1;
      valid = 1'b1; data = v.word; en = 1'b1;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!bus_m.load_ready && guard < 20);
      chk({tag, "_accept"}, bus_m.load_ready, 1);
      @(posedge clk); #1;
      valid = 1'b0; data = 8'($urandom);
      guard = 0;
      while (guard < 40) begin
         if (consumed == v.stall_bit && stalled < v.stall_len) begin
            en = 1'b0;
            stalled++;
         end else begin
            en = 1'b1;
         end
         @(negedge clk);
         if (!bus_m.busy) break;
         cycles++;
         chk({tag, "_count"}, bus_m.dbg_count, consumed);
         chk({tag, "_last"}, bus_m.last_bit, (consumed == 7));
         if (en) begin
            rec_m = {rec_m[6:0], bus_m.serial_data_output};
            rec_l = {rec_l[6:0], bus_l.serial_data_output};
            consumed++;
         end
         @(posedge clk); #1;
         guard++;
      end
      chk({tag, "_timeout"}, (guard < 40), 1);
      chk({tag, "_stream_m"}, rec_m, v.exp_m);
      chk({tag, "_stream_l"}, rec_l, v.exp_l);
      chk({tag, "_cycles"}, cycles, v.exp_cycles);
   endtask

   initial begin
      logic [15:0] rec16;
      int          guard;
      bit          acc;

      vecs[0] = '{8'hE1, 0, 0, 8'b1110_0001, 8'b1000_0111, 8};
      vecs[1] = '{8'hA5, 1, 3, 8'b1010_0101, 8'b1010_0101, 11};
      vecs[2] = '{8'h96, 7, 2, 8'b1001_0110, 8'b0110_1001, 10};
      vecs[3] = '{8'h01, 0, 1, 8'b0000_0001, 8'b1000_0000, 9};

      rst = 1'b1; valid = 1'b0; data = '0; en = 1'b0;
      repeat (2) @(posedge clk);
      #1 mon_on = 1'b1;
      @(negedge clk);
      chk("rst_outputs", {bus_m.busy, bus_m.serial_valid, bus_m.serial_data_output, bus_m.last_bit}, 4'b0);
      chk("rst_count", bus_m.dbg_count, 0);
      chk("rst_ready", bus_m.load_ready, 0);
      @(posedge clk); #1 rst = 1'b0; en = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", bus_m.load_ready, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_ignores_enable", bus_m.busy, 0);

      for (int i = 0; i < 4; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back frames with load_valid held across the boundary.
      @(posedge clk); #1 valid = 1'b1; data = 8'hC3; en = 1'b1;
      @(negedge clk);
      chk("b2b_ready_idle", bus_m.load_ready, 1);
      @(posedge clk); #1 data = 8'h3C;
      rec16 = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("b2b_busy", bus_m.busy, 1);
         chk("b2b_ready", bus_m.load_ready, ((i == 7) || (i == 15)));
         rec16 = {rec16[14:0], bus_m.serial_data_output};
         @(posedge clk); #1;
         if (i == 7) valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b_idle", bus_m.busy, 0);
      chk("b2b_stream", rec16, 16'b1100_0011_0011_1100);

      // Reset arriving mid-frame drops the frame.
      @(posedge clk); #1 valid = 1'b1; data = 8'h5A;
      @(negedge clk);
      @(posedge clk); #1 valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1; valid = 1'b1; data = 8'hFF;
      @(negedge clk);
      chk("midrst_ready", bus_m.load_ready, 0);
      @(posedge clk); #1 rst = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk("midrst_outputs", {bus_m.busy, bus_m.serial_valid, bus_m.serial_data_output, bus_m.last_bit}, 4'b0);
      chk("midrst_state", {bus_m.dbg_state, bus_l.dbg_state}, 2'b00);
      chk("midrst_count", bus_m.dbg_count, 0);
      chk("midrst_ready_after", bus_m.load_ready, 1);

      // A word offered mid-frame waits until the last bit.
      @(posedge clk); #1 valid = 1'b1; data = 8'h69;
      @(negedge clk);
      @(posedge clk); #1 valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 valid = 1'b1; data = 8'hFF;
      for (int i = 2; i < 8; i++) begin
         @(negedge clk);
         chk("midload_ready", bus_m.load_ready, (i == 7));
         @(posedge clk); #1;
      end
      valid = 1'b0; data = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("midload_ff", {bus_m.busy, bus_m.serial_data_output, bus_l.serial_data_output}, 3'b111);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("midload_idle", bus_m.busy, 0);

      // Random words under a random bit-rate strobe.
      for (int r = 0; r < 8; r++) begin
         @(posedge clk); #1 valid = 1'b1; data = 8'($urandom);
         acc = 1'b0; guard = 0;
         while (!acc && guard < 200) begin
            en = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus_m.load_ready;
            @(posedge clk); #1;
            guard++;
         end
         chk("rand_accept", acc, 1);
         valid = 1'b0;
      end
      en = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("drain_idle", bus_m.busy, 0);
      chk("drain_q_m", exp_m_q.size(), 0);
      chk("drain_q_l", exp_l_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_cmp++;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
